// File: rtl/packet_serializer.sv
// packet_serializer: pops 32-bit packets and sends each as a 4-byte MSB-first burst followed by an idle gap
module packet_serializer #(
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pkt_in_avail,
    input  logic [31:0]      pkt_in,
    output logic             read_data,
    input  logic             dest_full,
    output logic             send_data,
    output logic [7:0]       payload,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    state_t      r_state, w_next;
    logic [31:0] r_sr;
    logic [1:0]  r_bi, w_bn;
    logic [3:0]  r_gc;
    logic        w_last_gap, w_start;
    assign w_last_gap = r_state == GAP && r_gc == GAP_LAST;
    // gated by reset_n so the pop strobe is also silent while reset is held
    assign w_start = reset_n & pkt_in_avail & ~dest_full & (r_state == IDLE | w_last_gap);
    assign read_data = w_start;
    assign busy = r_state != IDLE;
    assign w_bn = r_bi + 2'd1;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (w_start) w_next = SEND;
        else if (r_state == SEND && r_bi == 2'd3) w_next = GAP;
        else if (w_last_gap) w_next = IDLE;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sr      <= '0;
            r_bi      <= '0;
            r_gc      <= '0;
            send_data <= 1'b0;
            payload   <= '0;
            pkt_count <= '0;
        end else if (w_start) begin
            r_sr      <= pkt_in;
            r_bi      <= '0;
            send_data <= 1'b1;
            payload   <= pkt_in[31:24];
        end else if (r_state == SEND) begin
            if (r_bi == 2'd3) begin
                send_data <= 1'b0;
                payload   <= '0;
                r_gc      <= '0;
                pkt_count <= pkt_count + CNT_W'(1);
            end else begin
                r_bi    <= w_bn;
                payload <= 8'(r_sr >> {~w_bn, 3'b000});
            end
        end else if (r_state == GAP) r_gc <= r_gc + 4'd1;
    end
endmodule

// File: tb/tb_packet_serializer.sv
// tb_packet_serializer: directed checks of framing, backpressure, reset and parameter variants
module tb_packet_serializer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0, rst2_n = 1'b0;
    logic        avail = 1'b0, dest_full = 1'b0;
    logic [31:0] pkt = '0;
    logic        rd_a, sd_a, busy_a;
    logic [7:0]  pl_a;
    logic [15:0] cnt_a;
    logic        avail2 = 1'b0;
    logic [31:0] pkt2 = 32'h0F1E2D3C;
    logic        rd_g, sd_g, busy_g, rd_w, sd_w, busy_w;
    logic [7:0]  pl_g, pl_w;
    logic [15:0] cnt_g;
    logic [1:0]  cnt_w;
    logic [31:0] q[$];
    int          checks = 0, failures = 0;

    always #5 clock = ~clock;

    packet_serializer u_a (.clock(clock), .reset_n(reset_n), .pkt_in_avail(avail), .pkt_in(pkt),
        .read_data(rd_a), .dest_full(dest_full), .send_data(sd_a), .payload(pl_a), .busy(busy_a),
        .pkt_count(cnt_a));
    packet_serializer #(.GAP_CYCLES(3)) u_g (.clock(clock), .reset_n(rst2_n), .pkt_in_avail(avail2),
        .pkt_in(pkt2), .read_data(rd_g), .dest_full(1'b0), .send_data(sd_g), .payload(pl_g),
        .busy(busy_g), .pkt_count(cnt_g));
    packet_serializer #(.CNT_W(2)) u_w (.clock(clock), .reset_n(rst2_n), .pkt_in_avail(avail2),
        .pkt_in(pkt2), .read_data(rd_w), .dest_full(1'b0), .send_data(sd_w), .payload(pl_w),
        .busy(busy_w), .pkt_count(cnt_w));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] p, input int k);
        return 8'(p >> (8 * (3 - k)));
    endfunction

    // one clock: the source FIFO model pops on a sampled read_data, then presents its new head
    task automatic cycle(input logic df);
        logic rd;
        #1 rd = rd_a;
        @(posedge clock);
        #1;
        if (rd && q.size() != 0) void'(q.pop_front());
        avail = q.size() != 0;
        pkt = q.size() != 0 ? q[0] : 32'h0;
        dest_full = df;
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        q.delete();
        cycle(1'b0);
        cycle(1'b0);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic expect_burst(input string tag, input logic [31:0] p);
        for (int k = 0; k < 4; k++) begin
            cycle(dest_full);
            check({tag, "_sd"}, 32'(sd_a), 32'd1);
            check({tag, "_pl"}, 32'(pl_a), 32'(byte_of(p, k)));
        end
    endtask

    initial begin
        #2;
        check("rst_sd", 32'(sd_a), 0);
        check("rst_pl", 32'(pl_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        check("rst_rd", 32'(rd_a), 0);
        do_reset();

        // single packet
        q.push_back(32'hA1B2C3D4);
        cycle(1'b0);
        check("s_rd", 32'(rd_a), 1);
        check("s_busy0", 32'(busy_a), 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0);
            check("s_rd_off", 32'(rd_a), 0);
            check("s_sd", 32'(sd_a), 1);
            check("s_pl", 32'(pl_a), 32'(byte_of(32'hA1B2C3D4, k)));
        end
        cycle(1'b0);
        check("s_gap_sd", 32'(sd_a), 0);
        check("s_gap_pl", 32'(pl_a), 0);
        check("s_gap_busy", 32'(busy_a), 1);
        check("s_cnt", 32'(cnt_a), 1);
        cycle(1'b0);
        check("s_idle_busy", 32'(busy_a), 0);

        // back-to-back, three packets, period 5
        do_reset();
        q.push_back(32'h11223344);
        q.push_back(32'h55667788);
        q.push_back(32'h99AABBCC);
        cycle(1'b0);
        check("b_rd0", 32'(rd_a), 1);
        for (int j = 1; j <= 15; j++) begin
            logic [31:0] p;
            p = j <= 5 ? 32'h11223344 : j <= 10 ? 32'h55667788 : 32'h99AABBCC;
            if (j == 10) p = 32'h55667788;
            cycle(1'b0);
            check("b_sd", 32'(sd_a), (j % 5) != 0);
            check("b_pl", 32'(pl_a), (j % 5) != 0 ? 32'(byte_of(p, (j % 5) - 1)) : 0);
            check("b_rd", 32'(rd_a), j == 5 || j == 10);
        end
        check("b_cnt", 32'(cnt_a), 3);

        // backpressure: ten full cycles, then release
        q.push_back(32'hDEADBEEF);
        cycle(1'b1);
        for (int j = 0; j < 10; j++) begin
            check("bp_rd", 32'(rd_a), 0);
            check("bp_busy", 32'(busy_a), 0);
            cycle(j == 9 ? 1'b0 : 1'b1);
        end
        check("bp_rel_rd", 32'(rd_a), 1);
        expect_burst("bp", 32'hDEADBEEF);
        cycle(1'b0);
        check("bp_cnt", 32'(cnt_a), 4);
        cycle(1'b0);

        // dest_full rises during byte 1: packet completes, next pop waits
        q.push_back(32'h01020304);
        q.push_back(32'h05060708);
        cycle(1'b0);
        check("mf_rd", 32'(rd_a), 1);
        cycle(1'b0);
        check("mf_b0", 32'(pl_a), 32'h01);
        cycle(1'b1);
        check("mf_b1", 32'(pl_a), 32'h02);
        cycle(1'b1);
        check("mf_b2", 32'(pl_a), 32'h03);
        check("mf_b2_sd", 32'(sd_a), 1);
        cycle(1'b1);
        check("mf_b3", 32'(pl_a), 32'h04);
        cycle(1'b1);
        check("mf_gap_rd", 32'(rd_a), 0);
        check("mf_gap_sd", 32'(sd_a), 0);
        cycle(1'b1);
        check("mf_idle_rd", 32'(rd_a), 0);
        check("mf_idle_busy", 32'(busy_a), 0);
        cycle(1'b0);
        check("mf_rel_rd", 32'(rd_a), 1);
        expect_burst("mf2", 32'h05060708);
        cycle(1'b0);
        check("mf_cnt", 32'(cnt_a), 6);
        cycle(1'b0);

        // asynchronous reset during byte 2
        q.push_back(32'hCAFEF00D);
        q.push_back(32'h12345678);
        cycle(1'b0);
        check("rm_rd", 32'(rd_a), 1);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        check("rm_b2", 32'(pl_a), 32'hF0);
        reset_n = 1'b0;
        #1;
        check("rm_sd", 32'(sd_a), 0);
        check("rm_pl", 32'(pl_a), 0);
        check("rm_busy", 32'(busy_a), 0);
        check("rm_cnt", 32'(cnt_a), 0);
        check("rm_rd_held", 32'(rd_a), 0);
        cycle(1'b0);
        reset_n = 1'b1;
        #1;
        check("rm_rel_rd", 32'(rd_a), 1);
        check("rm_rel_busy", 32'(busy_a), 0);
        expect_burst("rm", 32'h12345678);
        cycle(1'b0);
        check("rm_cnt1", 32'(cnt_a), 1);

        // GAP_CYCLES=3 and CNT_W=2 variants on a continuously available source
        avail2 = 1'b1;
        rst2_n = 1'b1;
        #1;
        check("v_rd_g0", 32'(rd_g), 1);
        check("v_rd_w0", 32'(rd_w), 1);
        for (int j = 1; j <= 25; j++) begin
            cycle(1'b0);
            check("g_sd", 32'(sd_g), (j % 7) >= 1 && (j % 7) <= 4);
            check("g_pl", 32'(pl_g), ((j % 7) >= 1 && (j % 7) <= 4) ? 32'(byte_of(32'h0F1E2D3C, (j % 7) - 1)) : 0);
            check("g_rd", 32'(rd_g), (j % 7) == 0);
            check("w_sd", 32'(sd_w), (j % 5) != 0);
            check("w_cnt", 32'(cnt_w), (j / 5) % 4);
        end
        check("g_cnt", 32'(cnt_g), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
